alu_muldiv_ctrl: RTL and testbench

Parametrised, registered successor to the combinational ALU-control decoder in the datapath. It decodes `aluop`/`funct`, executes single-cycle ALU operations and multi-cycle unsigned multiply/divide, and holds HI/LO. It sits between the main control unit and the writeback path. Multi-cycle operations stall issue through a `ready`/`valid_in` handshake.

---
 rtl/alu_muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// Registered ALU with decoder for aluop/funct, plus multi-cycle unsigned multiply/divide and HI/LO.
// Multiply is shift-add and divide is restoring; each takes WIDTH iterations while ready is low.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             result_valid,
  output logic             illegal,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_ILL
  } op_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               zero_q, zero_d, rv_q, rv_d, ill_q, ill_d, dz_q, dz_d;

  op_t              op;
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    op = OP_ILL;
    case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      default: begin
        case (funct)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b101011: op = OP_SLTU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          6'b011001: op = OP_MULTU;
          6'b011011: op = OP_DIVU;
          default:   op = OP_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc = {partial high, remaining multiplier bits}; add multiplicand when LSB set, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left and subtract divisor when it fits.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
  assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    zero_d   = zero_q;
    rv_d     = 1'b0;
    ill_d    = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (op == OP_MULTU) begin
            state_d = S_MUL;
            cnt_d   = CW'(WIDTH-1);
            opnd_d  = a;
            acc_d   = {{WIDTH{1'b0}}, b};
          end else if (op == OP_DIVU && b == '0) begin
            hi_d     = a;
            lo_d     = '1;
            result_d = '1;
            zero_d   = 1'b0;
            rv_d     = 1'b1;
            dz_d     = 1'b1;
          end else if (op == OP_DIVU) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH-1);
            opnd_d  = b;
            acc_d   = {{WIDTH{1'b0}}, a};
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            rv_d     = 1'b1;
            ill_d    = (op == OP_ILL);
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          hi_d     = acc_d[2*WIDTH-1:WIDTH];
          lo_d     = acc_d[WIDTH-1:0];
          result_d = acc_d[WIDTH-1:0];
          zero_d   = (acc_d[WIDTH-1:0] == '0);
          rv_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      rv_q     <= 1'b0;
      ill_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rv_q     <= rv_d;
      ill_q    <= ill_d;
      dz_q     <= dz_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign ready        = ~busy;
  assign result       = result_q;
  assign zero         = zero_q;
  assign result_valid = rv_q;
  assign illegal      = ill_q;
  assign dz           = dz_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench: vector table for single-cycle ops (WIDTH=32) plus mul/div, stall and reset sequences.
module tb_alu_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        valid32 = 1'b0;
  logic [1:0]  aluop32 = '0;
  logic [5:0]  funct32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready32, busy32, zero32, rv32, ill32, dz32;
  logic [31:0] result32, hi32, lo32;

  alu_muldiv_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .valid_in(valid32), .aluop(aluop32), .funct(funct32),
    .a(a32), .b(b32), .ready(ready32), .busy(busy32), .result(result32), .zero(zero32),
    .result_valid(rv32), .illegal(ill32), .dz(dz32), .hi(hi32), .lo(lo32));

  // WIDTH=8 instance
  logic       valid8 = 1'b0;
  logic [1:0] aluop8 = '0;
  logic [5:0] funct8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, zero8, rv8, ill8, dz8;
  logic [7:0] result8, hi8, lo8;

  alu_muldiv_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .valid_in(valid8), .aluop(aluop8), .funct(funct8),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8), .result(result8), .zero(zero8),
    .result_valid(rv8), .illegal(ill8), .dz(dz8), .hi(hi8), .lo(lo8));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  vec_t vt[13];

  // Issue a mul/div on the 8-bit DUT and watch it to completion.
  task automatic run8(input logic [5:0] f, input logic [7:0] av, input logic [7:0] bv,
                      output int nb, output int nrv);
    @(negedge clk);
    aluop8 = 2'b10; funct8 = f; a8 = av; b8 = bv; valid8 = 1'b1;
    @(negedge clk);
    valid8 = 1'b0;
    nb = 0; nrv = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy8) nb++;
      if (rv8) begin nrv++; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nrv;
    bit seen;

    vt[0]  = '{2'b10, 6'b100100, 32'h0000000F, 32'h000000F0, 32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{2'b10, 6'b100101, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
    vt[2]  = '{2'b10, 6'b100110, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
    vt[3]  = '{2'b10, 6'b100111, 32'h0000000F, 32'h000000F0, 32'hFFFFFF00, 1'b0, 1'b0};
    vt[4]  = '{2'b10, 6'b100010, 32'h0000000F, 32'h000000F0, 32'hFFFFFF1F, 1'b0, 1'b0};
    vt[5]  = '{2'b10, 6'b100000, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
    vt[6]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vt[7]  = '{2'b10, 6'b101011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vt[8]  = '{2'b10, 6'b111111, 32'h0000000F, 32'h000000F0, 32'h00000000, 1'b1, 1'b1};
    vt[9]  = '{2'b00, 6'b111111, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1'b0};
    vt[10] = '{2'b01, 6'b100000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vt[11] = '{2'b11, 6'b000000, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0};
    vt[12] = '{2'b00, 6'b000000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy", busy32, 0);
    chk("rst_ready", ready32, 1);
    chk("rst_result", result32, 0);
    chk("rst_zero", zero32, 1);
    chk("rst_rv", rv32, 0);
    chk("rst_hilo", {hi32, lo32}, 0);
    chk("rst8_zero", zero8, 1);

    // Back-to-back single-cycle ops: result_valid must be high on every cycle.
    for (int i = 0; i < 13; i++) begin
      aluop32 = vt[i].aluop; funct32 = vt[i].funct; a32 = vt[i].a; b32 = vt[i].b; valid32 = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_result", i), result32, vt[i].exp);
      chk($sformatf("vec%0d_zero", i), zero32, vt[i].exp_zero);
      chk($sformatf("vec%0d_ill", i), ill32, vt[i].exp_ill);
      chk($sformatf("vec%0d_rv", i), rv32, 1);
      chk($sformatf("vec%0d_dz", i), dz32, 0);
    end
    valid32 = 1'b0;
    @(negedge clk);
    chk("idle_rv", rv32, 0);
    chk("hold_result", result32, 32'h1);

    // Stall: multu 0x10000*0x10000 then add(1,1) held while busy.
    aluop32 = 2'b10; funct32 = 6'b011001; a32 = 32'h00010000; b32 = 32'h00010000; valid32 = 1'b1;
    @(negedge clk);
    chk("mul_busy", busy32, 1);
    chk("mul_ready", ready32, 0);
    funct32 = 6'b100000; a32 = 32'd1; b32 = 32'd1;
    nb = 1; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rv32) begin seen = 1'b1; break; end
      if (busy32) nb++;
    end
    chk("mul_done_seen", seen, 1);
    chk("mul_busy_cycles", nb, 32);
    chk("mul_result", result32, 0);
    chk("mul_hi", hi32, 1);
    chk("mul_lo", lo32, 0);
    chk("mul_zero", zero32, 1);
    @(negedge clk);
    chk("stall_add_rv", rv32, 1);
    chk("stall_add_result", result32, 2);
    funct32 = 6'b010000;
    @(negedge clk);
    chk("mfhi", result32, 1);
    funct32 = 6'b010010;
    @(negedge clk);
    chk("mflo", result32, 0);
    chk("mflo_zero", zero32, 1);
    chk("mflo_rv", rv32, 1);
    valid32 = 1'b0;
    @(negedge clk);
    chk("hi_hold", hi32, 1);

    // Reset five cycles into a multiply.
    funct32 = 6'b011001; a32 = 32'd3; b32 = 32'd5; valid32 = 1'b1;
    @(negedge clk);
    valid32 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy32, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy32, 0);
    chk("midrst_ready", ready32, 1);
    chk("midrst_hilo", {hi32, lo32}, 0);
    chk("midrst_zero", zero32, 1);
    chk("midrst_result", result32, 0);
    @(negedge clk);
    reset = 1'b0;
    aluop32 = 2'b10; funct32 = 6'b100000; a32 = 32'd2; b32 = 32'd3; valid32 = 1'b1;
    @(negedge clk);
    valid32 = 1'b0;
    chk("postrst_add", result32, 5);
    chk("postrst_rv", rv32, 1);

    // WIDTH=8 multiply
    run8(6'b011001, 8'hFF, 8'hFF, nb, nrv);
    chk("mul8_busy_cycles", nb, 8);
    chk("mul8_rv", nrv, 1);
    chk("mul8_hi", hi8, 8'hFE);
    chk("mul8_lo", lo8, 8'h01);
    chk("mul8_result", result8, 8'h01);
    @(negedge clk);
    chk("mul8_rv_pulse", rv8, 0);

    // WIDTH=8 divide
    run8(6'b011011, 8'd200, 8'd7, nb, nrv);
    chk("div8_busy_cycles", nb, 8);
    chk("div8_rv", nrv, 1);
    chk("div8_lo", lo8, 8'd28);
    chk("div8_hi", hi8, 8'd4);
    chk("div8_result", result8, 8'd28);
    chk("div8_dz", dz8, 0);

    // WIDTH=8 divide by zero: single cycle, never busy
    run8(6'b011011, 8'd200, 8'd0, nb, nrv);
    chk("dz8_busy_cycles", nb, 0);
    chk("dz8_rv", nrv, 1);
    chk("dz8_dz", dz8, 1);
    chk("dz8_hi", hi8, 8'd200);
    chk("dz8_lo", lo8, 8'hFF);
    chk("dz8_result", result8, 8'hFF);
    chk("dz8_zero", zero8, 0);
    @(negedge clk);
    chk("dz8_pulse", dz8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
